// File: rtl/riot_pkg.sv
// rtl/riot_pkg.sv - shared constants for the RIOT-style I/O timer
package riot_pkg;

  typedef enum logic [1:0] {
    PS_1    = 2'd0,
    PS_8    = 2'd1,
    PS_64   = 2'd2,
    PS_1024 = 2'd3
  } ps_e;

  localparam logic [3:0] ADDR_TIMER  = 4'h8;  // 8..B, low bits pick the prescale
  localparam logic [3:0] ADDR_TCOUNT = 4'hC;
  localparam logic [3:0] ADDR_FLAGS  = 4'hD;
  localparam logic [3:0] ADDR_IER    = 4'hE;

  localparam int FLAG_TIMER = 0;
  localparam int FLAG_EDGE  = 1;

  localparam int PSC_W = 10;

  function automatic logic [3:0] ps_shift(ps_e ps);
    case (ps)
      PS_1:    return 4'd0;
      PS_8:    return 4'd3;
      PS_64:   return 4'd6;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [PSC_W-1:0] ps_max(ps_e ps);
    return PSC_W'((1 << ps_shift(ps)) - 1);
  endfunction

endpackage

// File: rtl/riot_io_timer_if.sv
// rtl/riot_io_timer_if.sv - CPU register bus between decoder and the I/O timer
interface riot_io_timer_if #(
  parameter int DATA_W = 8
);
  logic              cs;
  logic              we;
  logic [3:0]        addr;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] dout;
  logic              oe;

  modport master (output cs, we, addr, di, input dout, oe);
  modport slave  (input cs, we, addr, di, output dout, oe);
endinterface

// File: rtl/riot_timer.sv
// rtl/riot_timer.sv - interval timer: prescaler, down-counter, free-run after underflow
module riot_timer
  import riot_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  ps_e               ps_sel,
  output logic [DATA_W-1:0] count,
  output logic              underflow
);

  logic [PSC_W-1:0] psc;
  ps_e              ps_q;
  logic             free_run;
  logic             wrap;
  logic             tick;

  assign wrap = (psc == ps_max(ps_q));
  assign tick = free_run || wrap;
  // A load in the same cycle suppresses the underflow so the write wins.
  assign underflow = tick && (count == '0) && !load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '1;
      psc      <= '0;
      ps_q     <= PS_1024;
      free_run <= 1'b0;
    end else if (load) begin
      count    <= load_val;
      psc      <= '0;
      ps_q     <= ps_sel;
      free_run <= 1'b0;
    end else begin
      psc <= wrap ? '0 : psc + 1'b1;
      if (tick) begin
        if (count == '0) begin
          count    <= '1;
          free_run <= 1'b1;
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riot_io_timer.sv
// rtl/riot_io_timer.sv - parametrised I/O ports, interval timer, edge interrupt, register bus
module riot_io_timer
  import riot_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          phi2,
  input  logic                          rst,
  riot_io_timer_if.slave                bus,
  input  logic [NUM_PORTS*DATA_W-1:0]   p_i,
  output logic [NUM_PORTS*DATA_W-1:0]   p_o,
  output logic [NUM_PORTS*DATA_W-1:0]   p_ddr,
  output logic                          irq
);

  localparam int PW = NUM_PORTS * DATA_W;

  logic [PW-1:0]     sync_q [SYNC_STAGES];
  logic [PW-1:0]     pin;
  logic              edge_prev;
  logic              edge_pol;
  logic              edge_hit;
  logic [1:0]        flags;
  logic [1:0]        ier;
  logic              rd;
  logic              wr;
  logic [1:0]        port_idx;
  logic              port_ok;
  logic              timer_load;
  logic              underflow;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] sel_o;
  logic [DATA_W-1:0] sel_ddr;
  logic [DATA_W-1:0] sel_pin;
  logic [DATA_W-1:0] rdata;

  assign rd         = bus.cs && !bus.we;
  assign wr         = bus.cs && bus.we;
  assign port_idx   = bus.addr[2:1];
  assign port_ok    = !bus.addr[3] && (int'(port_idx) < NUM_PORTS);
  assign timer_load = wr && (bus.addr[3:2] == ADDR_TIMER[3:2]);
  assign pin        = sync_q[SYNC_STAGES-1];

  // Edge detection watches the pin even when the port bit is driven.
  assign edge_hit = edge_pol ? ( pin[DATA_W-1] && !edge_prev)
                             : (!pin[DATA_W-1] &&  edge_prev);

  riot_timer #(.DATA_W(DATA_W)) u_timer (
    .clk       (phi2),
    .rst       (rst),
    .load      (timer_load),
    .load_val  (bus.di),
    .ps_sel    (ps_e'(bus.addr[1:0])),
    .count     (count),
    .underflow (underflow)
  );

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_prev <= 1'b0;
    end else begin
      sync_q[0] <= p_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_prev <= pin[DATA_W-1];
    end
  end

  always_comb begin
    sel_o   = '0;
    sel_ddr = '0;
    sel_pin = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_idx == 2'(p)) begin
        sel_o   = p_o[p*DATA_W +: DATA_W];
        sel_ddr = p_ddr[p*DATA_W +: DATA_W];
        sel_pin = pin[p*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (port_ok) begin
      rdata = bus.addr[0] ? sel_ddr : ((sel_ddr & sel_o) | (~sel_ddr & sel_pin));
    end else begin
      case (bus.addr)
        ADDR_TCOUNT: rdata = count;
        ADDR_FLAGS:  rdata = DATA_W'(flags);
        ADDR_IER:    rdata = DATA_W'(ier);
        default:     rdata = '0;
      endcase
    end
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      p_o      <= '0;
      p_ddr    <= '0;
      edge_pol <= 1'b0;
      ier      <= 2'b00;
    end else if (wr) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!bus.addr[3] && port_idx == 2'(p)) begin
          if (bus.addr[0]) p_ddr[p*DATA_W +: DATA_W] <= bus.di;
          else             p_o[p*DATA_W +: DATA_W]   <= bus.di;
        end
      end
      if (bus.addr == ADDR_FLAGS) edge_pol <= bus.di[0];
      if (bus.addr == ADDR_IER)   ier      <= bus.di[1:0];
    end
  end

  // New events take priority over read-to-clear in the same cycle.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      flags <= 2'b00;
      irq   <= 1'b0;
    end else begin
      if (underflow)
        flags[FLAG_TIMER] <= 1'b1;
      else if (timer_load || (rd && bus.addr == ADDR_TCOUNT))
        flags[FLAG_TIMER] <= 1'b0;
      if (edge_hit)
        flags[FLAG_EDGE] <= 1'b1;
      else if (rd && bus.addr == ADDR_FLAGS)
        flags[FLAG_EDGE] <= 1'b0;
      irq <= |(flags & ier);
    end
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      bus.dout <= '0;
      bus.oe   <= 1'b0;
    end else begin
      bus.oe <= rd;
      if (rd) bus.dout <= rdata;
    end
  end

endmodule
